// File: rtl/rv_immenc_if.sv
// rv_immenc shared types and request/response bundle.
// Ports: i_valid/o_ready request, o_valid/i_ready response.
package rv_immenc_pkg;

  localparam logic [2:0] IMMEXT_CTRL_I = 3'd0;
  localparam logic [2:0] IMMEXT_CTRL_S = 3'd1;
  localparam logic [2:0] IMMEXT_CTRL_B = 3'd2;
  localparam logic [2:0] IMMEXT_CTRL_J = 3'd3;
  localparam logic [2:0] IMMEXT_CTRL_U = 3'd4;

  typedef struct packed {
    logic [2:0]  ctrl;
    logic [31:0] imm;
    logic [31:0] base;
    logic        err;
  } s1_t;

endpackage

interface rv_immenc_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_ctrl;
  logic [XLEN-1:0] i_imm;
  logic [31:0]     i_base_instr;
  logic            o_valid;
  logic            i_ready;
  logic [31:0]     o_instr;
  logic            o_err;

  modport master (
    output i_valid, i_ctrl, i_imm,
    output i_base_instr, i_ready,
    input  o_ready, o_valid,
    input  o_instr, o_err
  );

  modport slave (
    input  i_valid, i_ctrl, i_imm,
    input  i_base_instr, i_ready,
    output o_ready, o_valid,
    output o_instr, o_err
  );
endinterface

// File: rtl/rv_immenc.sv
// Two-stage immediate encoder: range check, then field scatter.
// Ports: i_clk, i_rstn, bus (slave), i_err_clr, o_err_cnt.
module rv_immenc #(
  parameter int XLEN      = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  rv_immenc_if.slave           bus,
  input  logic                 i_err_clr,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);
  import rv_immenc_pkg::*;

  logic            s1_valid;
  s1_t             s1_q;
  logic            s2_adv;
  logic            s1_adv;
  logic            out_hs;
  logic [XLEN-1:0] imm;
  logic [2:0]      c;
  logic            in_is;
  logic            in_b;
  logic            in_j;
  logic            err_d;
  logic            s1_i;
  logic            s1_s;
  logic            s1_b;
  logic            s1_j;
  logic [31:0]     instr_d;

  assign s2_adv      = !bus.o_valid | bus.i_ready;
  assign s1_adv      = !s1_valid | s2_adv;
  assign bus.o_ready = s1_adv;
  assign out_hs      = bus.o_valid & bus.i_ready;

  assign imm   = bus.i_imm;
  assign c     = bus.i_ctrl;
  assign in_is = (c == IMMEXT_CTRL_I)
               | (c == IMMEXT_CTRL_S);
  assign in_b  = (c == IMMEXT_CTRL_B);
  assign in_j  = (c == IMMEXT_CTRL_J);

  // Representable iff the bits above the
  // field's sign bit are a pure sign extension.
  always_comb begin
    err_d = 1'b0;
    unique case (1'b1)
      in_is: err_d = !(&imm[31:11]
                     | ~|imm[31:11]);
      in_b:  err_d = !(&imm[31:12]
                     | ~|imm[31:12])
                     | imm[0];
      in_j:  err_d = !(&imm[31:20]
                     | ~|imm[31:20])
                     | imm[0];
      default: err_d = |imm[11:0];
    endcase
  end

  assign s1_i = (s1_q.ctrl == IMMEXT_CTRL_I);
  assign s1_s = (s1_q.ctrl == IMMEXT_CTRL_S);
  assign s1_b = (s1_q.ctrl == IMMEXT_CTRL_B);
  assign s1_j = (s1_q.ctrl == IMMEXT_CTRL_J);

  always_comb begin
    instr_d = s1_q.base;
    unique case (1'b1)
      s1_i: instr_d[31:20] = s1_q.imm[11:0];
      s1_s: begin
        instr_d[31:25] = s1_q.imm[11:5];
        instr_d[11:7]  = s1_q.imm[4:0];
      end
      s1_b: begin
        instr_d[31]    = s1_q.imm[12];
        instr_d[30:25] = s1_q.imm[10:5];
        instr_d[11:8]  = s1_q.imm[4:1];
        instr_d[7]     = s1_q.imm[11];
      end
      s1_j: begin
        instr_d[31]    = s1_q.imm[20];
        instr_d[30:21] = s1_q.imm[10:1];
        instr_d[20]    = s1_q.imm[11];
        instr_d[19:12] = s1_q.imm[19:12];
      end
      default: instr_d[31:12] = s1_q.imm[31:12];
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.i_valid;
      if (bus.i_valid) begin
        s1_q.ctrl <= bus.i_ctrl;
        s1_q.imm  <= bus.i_imm;
        s1_q.base <= bus.i_base_instr;
        s1_q.err  <= err_d;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      bus.o_valid <= 1'b0;
      bus.o_instr <= '0;
      bus.o_err   <= 1'b0;
    end else if (s2_adv) begin
      bus.o_valid <= s1_valid;
      if (s1_valid) begin
        bus.o_instr <= instr_d;
        bus.o_err   <= s1_q.err;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_err_cnt <= '0;
    end else if (i_err_clr) begin
      o_err_cnt <= '0;
    end else if (out_hs & bus.o_err
                 & (o_err_cnt != '1)) begin
      o_err_cnt <= o_err_cnt + 1'b1;
    end
  end

endmodule
